// File: rtl/instr_assembler_pkg.sv
// rtl/instr_assembler_pkg.sv - opcode constants, op-class and FSM state types
package instr_assembler_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [2:0] {
    OPC_RTYPE = 3'd0,
    OPC_BEQ   = 3'd1,
    OPC_BNE   = 3'd2,
    OPC_SW    = 3'd3,
    OPC_LW    = 3'd4,
    OPC_ADDI  = 3'd5,
    OPC_J     = 3'd6,
    OPC_LUI   = 3'd7
  } op_class_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_FULL = 2'd3
  } state_e;

endpackage

// File: rtl/instr_assembler_field_pack.sv
// rtl/instr_assembler_field_pack.sv - combinational MIPS field packer with branch offset math
module instr_field_pack
  import instr_assembler_pkg::*;
#(
  parameter int AW = 8
) (
  input  op_class_e     op,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [5:0]    funct,
  input  logic [15:0]   imm,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] addr,
  output logic [31:0]   word
);

  // Offset is relative to the word after the branch, in AW+1-bit two's complement.
  logic [AW:0]  off_n;
  logic [15:0]  off16;

  assign off_n = {1'b0, target} - {1'b0, addr} - (AW+1)'(1);

  generate
    if (AW >= 15) begin : g_off_trunc
      assign off16 = off_n[15:0];
    end else begin : g_off_sext
      assign off16 = {{(15-AW){off_n[AW]}}, off_n};
    end
  endgenerate

  always_comb begin
    word = '0;
    case (op)
      OPC_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      OPC_BEQ:   word = {OP_BEQ, rs, rt, off16};
      OPC_BNE:   word = {OP_BNE, rs, rt, off16};
      OPC_SW:    word = {OP_SW, rs, rt, imm};
      OPC_LW:    word = {OP_LW, rs, rt, imm};
      OPC_ADDI:  word = {OP_ADDI, rs, rt, imm};
      OPC_J:     word = {OP_J, {(26-AW){1'b0}}, target};
      OPC_LUI:   word = {OP_LUI, 5'b00000, rt, imm};
      default:   word = '0;
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - load FSM, address counter and registered imem write port
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int IMEM_AW   = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [4:0]         in_rs,
  input  logic [4:0]         in_rt,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_shamt,
  input  logic [5:0]         in_funct,
  input  logic [15:0]        in_imm,
  input  logic [IMEM_AW-1:0] in_target,
  input  logic               in_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam logic [IMEM_AW-1:0] BASE     = IMEM_AW'(BASE_ADDR);
  localparam logic [IMEM_AW-1:0] TOP_ADDR = '1;

  state_e             state;
  logic [IMEM_AW-1:0] addr;
  logic [31:0]        word;
  logic               accept;

  assign accept = in_valid && (state == S_LOAD);

  instr_field_pack #(.AW(IMEM_AW)) u_pack (
    .op     (op_class_e'(in_op)),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .funct  (in_funct),
    .imm    (in_imm),
    .target (in_target),
    .addr   (addr),
    .word   (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= BASE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= addr;
        imem_wdata <= word;
      end
      // A word accepted alongside start lands at the old address; start governs what follows.
      if (start) begin
        state    <= S_LOAD;
        addr     <= BASE;
        in_ready <= 1'b1;
        busy     <= 1'b1;
        done     <= 1'b0;
        overflow <= 1'b0;
      end else if (accept) begin
        if (in_last) begin
          state    <= S_DONE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end else if (addr == TOP_ADDR) begin
          state    <= S_FULL;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          overflow <= 1'b1;
        end else begin
          addr <= addr + IMEM_AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// tb/tb_instr_assembler.sv - self-checking bench for instr_assembler
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, start2, in_valid2, in_last;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [7:0]  in_target;
  logic [1:0]  in_target2;

  logic        in_ready, imem_we, busy, done, overflow;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        rdy2, we2, busy2, done2, ovf2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;

  int checks = 0;
  int errors = 0;
  int exp_addr;

  always #5 clk = ~clk;

  instr_assembler #(.IMEM_AW(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .overflow(overflow)
  );

  instr_assembler #(.IMEM_AW(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(rdy2),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target2), .in_last(in_last),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .busy(busy2), .done(done2), .overflow(ovf2)
  );

  // Reference encoder: opcode table plus shifted fields, branch offset in plain integers.
  function automatic logic [31:0] model(input int op, input int rs, input int rt, input int rd,
                                        input int sh, input int fn, input int imm,
                                        input int tgt, input int at);
    int opc_tab [8] = '{0, 4, 5, 43, 35, 8, 2, 15};
    int off;
    logic [31:0] w;
    off = tgt - (at + 1);
    w = 32'(opc_tab[op]) << 26;
    case (op)
      0:       w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
      1, 2:    w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(off) & 32'hFFFF);
      3, 4, 5: w = w | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
      6:       w = w | 32'(tgt);
      default: w = w | (32'(rt) << 16) | 32'(imm);
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int op, input int rs, input int rt, input int rd, input int sh,
                          input int fn, input int imm, input int tgt, input logic last);
    in_op = 3'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_funct = 6'(fn); in_imm = 16'(imm); in_target = 8'(tgt); in_target2 = 2'(tgt);
    in_last = last;
  endtask

  task automatic set_rand(input logic last);
    set_word($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
             $urandom_range(0, 65535), $urandom_range(0, 255), last);
  endtask

  function automatic logic [31:0] cur_model(input int at, input int tgt);
    return model(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_shamt),
                 int'(in_funct), int'(in_imm), tgt, at);
  endfunction

  task automatic send_chk(input string tag);
    logic [31:0] exp_w;
    exp_w = cur_model(exp_addr, int'(in_target));
    in_valid = 1'b1;
    tick();
    chk({tag, "_we"}, 32'(imem_we), 32'd1);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
    chk({tag, "_wdata"}, imem_wdata, exp_w);
    exp_addr++;
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; start2 = 1'b0; in_valid2 = 1'b0;
    set_word(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    tick(); tick();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_flags", {28'd0, in_ready, busy, done, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // Single ADDI
    pulse_start();
    chk("start_flags", {28'd0, in_ready, busy, done, overflow}, 32'b1100);
    chk("start_no_we", 32'(imem_we), 32'd0);
    set_word(5, 0, 8, 0, 0, 0, 16'h0005, 0, 1'b1);
    send_chk("addi");
    chk("addi_lit", imem_wdata, 32'h20080005);
    chk("addi_flags", {28'd0, in_ready, busy, done, overflow}, 32'b0010);
    tick();
    chk("done_no_accept", 32'(imem_we), 32'd0);
    chk("done_hold", 32'(done), 32'd1);
    in_valid = 1'b0;

    // Back-to-back stream ending in a backward branch at addr 3
    pulse_start();
    set_word(0, 8, 9, 10, 0, 6'h20, 0, 0, 1'b0);
    send_chk("rtype");
    chk("rtype_lit", imem_wdata, 32'h01095020);
    set_rand(1'b0); if (in_op == 3'd7 || in_op == 3'd1 || in_op == 3'd2 || in_op == 3'd6) in_op = 3'd3;
    send_chk("b2b1");
    set_rand(1'b0);
    send_chk("b2b2");
    set_word(1, 8, 9, 0, 0, 0, 0, 1, 1'b1);
    send_chk("beq");
    chk("beq_lit", imem_wdata, 32'h1109FFFD);
    in_valid = 1'b0;

    // Jump and LUI
    pulse_start();
    set_word(6, 0, 0, 0, 0, 0, 0, 8'h10, 1'b0);
    send_chk("j");
    chk("j_lit", imem_wdata, 32'h08000010);
    set_word(7, 7, 1, 0, 0, 0, 16'h1234, 0, 1'b1);
    send_chk("lui");
    chk("lui_lit", imem_wdata, 32'h3C011234);
    in_valid = 1'b0;

    // Randomized stream with idle gaps
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      set_rand(i == 23);
      if (i != 23 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
        chk("rand_gap_we", 32'(imem_we), 32'd0);
      end
      send_chk("rand");
    end
    chk("rand_done", 32'(done), 32'd1);
    in_valid = 1'b0;

    // Overflow on the 2-bit instance
    start2 = 1'b1; tick(); start2 = 1'b0;
    set_word(5, 1, 2, 0, 0, 0, 16'h00AA, 0, 1'b0);
    in_valid2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_imm = 16'(k);
      tick();
      chk("ovf_we", 32'(we2), 32'd1);
      chk("ovf_addr", 32'(addr2), 32'(k));
      chk("ovf_wdata", wdata2, model(5, 1, 2, 0, 0, 0, k, 0, k));
    end
    chk("ovf_flags", {28'd0, rdy2, busy2, done2, ovf2}, 32'b0001);
    tick();
    chk("ovf_5th_rejected", 32'(we2), 32'd0);
    chk("ovf_hold", 32'(ovf2), 32'd1);
    in_valid2 = 1'b0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("ovf_cleared", {28'd0, rdy2, busy2, done2, ovf2}, 32'b1100);
    in_valid2 = 1'b1; tick(); in_valid2 = 1'b0;
    chk("ovf_resume_addr", {31'd0, we2} | (32'(addr2) << 1), 32'd1);

    // start together with an accepted word in LOAD
    pulse_start();
    set_rand(1'b0);
    send_chk("restart_a");
    set_rand(1'b0);
    start = 1'b1;
    send_chk("restart_b");
    start = 1'b0;
    exp_addr = 0;
    set_rand(1'b1);
    send_chk("restart_c");
    in_valid = 1'b0;

    // Reset mid-stream
    pulse_start();
    set_rand(1'b0);
    send_chk("pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_we", 32'(imem_we), 32'd0);
    chk("rst_mid_flags", {28'd0, in_ready, busy, done, overflow}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle_we", 32'(imem_we), 32'd0);
    pulse_start();
    set_rand(1'b1);
    send_chk("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_assembler.md
# instr_assembler

- Sequential instruction-stream encoder that packs decoded instruction fields into 32-bit MIPS words and writes them sequentially into instruction memory.
- Supports the opcode set the main control decoder recognises: R-type, beq, bne, sw, lw, addi, j, lui.
- Used by the bench and boot path to load programs into the single-cycle CPU.
- Field valid/ready handshake in; registered single-port memory write out.

## Interface

Parameters:
- IMEM_AW, 8, instruction-memory word-address width (2..16)
- BASE_ADDR, 0, first word address written after start

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new load at BASE_ADDR; clears done/overflow
- in_valid  in  1  field bundle valid
- in_ready  out  1  high only in state LOAD
- in_op  in  3  op class: 0 RTYPE, 1 BEQ, 2 BNE, 3 SW, 4 LW, 5 ADDI, 6 J, 7 LUI
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_funct  in  6  R-type function
- in_imm  in  16  immediate (SW/LW/ADDI/LUI)
- in_target  in  IMEM_AW  absolute word address (BEQ/BNE/J)
- in_last  in  1  final word of program
- imem_we  out  1  memory write strobe
- imem_addr  out  IMEM_AW  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state == LOAD
- done  out  1  state == DONE
- overflow  out  1  state == FULL

## Operation

- **States and transitions:**
  - IDLE → LOAD on start.
  - LOAD → DONE on accepting an in_last word.
  - LOAD → FULL on accepting a non-last word at address 2^IMEM_AW−1.
  - DONE/FULL → LOAD on start.
  - start in LOAD restarts at BASE_ADDR.
- **Accept:** in_valid && in_ready. in_ready is decoded from the current state only, so it is low in the cycle start is asserted from IDLE/DONE/FULL.
- **Address counter:**
  - Loaded with BASE_ADDR on start.
  - Increments per accept.
  - No wrap: reaching the top address ends the load in FULL.
- **Encoding** (opcode bits [31:26]):
  - RTYPE: {000000, rs, rt, rd, shamt, funct}
  - BEQ 000100 / BNE 000101: {op, rs, rt, off16}
    - off16 = in_target − (addr+1), computed in IMEM_AW+1-bit signed arithmetic, then sign-extended to 16 bits.
  - SW 101011 / LW 100011 / ADDI 001000: {op, rs, rt, imm}
  - J 000010: {op, in_target zero-extended to 26 bits}
  - LUI 001111: {op, 00000, rt, imm}. in_rs is ignored.
- **Unused fields:** ignored per op. Encoding is pure field packing with no operand validation.
- **Reset:** state IDLE, address BASE_ADDR. All outputs 0: imem_we, imem_addr, imem_wdata, busy, done, overflow, in_ready.

## Timing

- **Latency:** word accepted in cycle N produces imem_we=1 with its imem_addr and imem_wdata in cycle N+1, for one cycle.
- **Throughput:** one word per cycle while in_valid is held high.
- **done and overflow:** assert in cycle N+1, the same cycle as the final write. Both hold until start or rst.
- **start during a write:** a write already registered (imem_we high in the start cycle) completes at its original address.
- **rst mid-stream:** imem_we and all outputs drop asynchronously. No partial write occurs after reset release.
- **Simultaneous start + in_valid in LOAD:** the word is accepted at the old address and the counter reloads to BASE_ADDR. The start takes effect for subsequent words.

## Structure

- **Shared package** (shared with the main control decoder):
  - 6-bit opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW, OP_ADDI, OP_J, OP_LUI.
  - 3-bit op-class enum.
  - FSM state enum.
- **Sub-module:** instr_field_pack, a combinational packer taking (op class, fields, current addr) and returning the 32-bit word, including branch offset math. The top level holds the FSM, counter and output register.

## Test plan

1. **Single ADDI:** start, then ADDI rs=0 rt=8 imm=0x0005 in_last=1 → next cycle imem_we=1, addr=0, wdata=0x20080005, done=1, busy=0.
2. **Back-to-back stream:** three words with in_valid held (R-type rs=8 rt=9 rd=10 funct=0x20 first) → writes at addr 0,1,2 on consecutive cycles; first wdata=0x01095020.
3. **Backward branch:** BEQ rs=8 rt=9 accepted at addr 3 with in_target=1 → wdata=0x1109FFFD (offset −3).
4. **Jump and LUI:** J in_target=0x10 → 0x08000010; LUI rt=1 imm=0x1234 (rs=7) → 0x3C011234.
5. **Overflow:** IMEM_AW=2, five non-last words offered → four writes at addr 0..3, overflow=1 and in_ready=0 from the cycle after the 4th accept, 5th never accepted. start then resumes at addr 0 with overflow cleared.
6. **Reset mid-stream:** rst asserted while imem_we=1 → imem_we, busy, done, overflow drop immediately. After release and start, the first write goes to BASE_ADDR.
